// File: rtl/store_unit.sv
// Store buffer between the pipeline and the memory write port.
// Each store is aligned into an 8-byte lane (address, byte mask and
// lane-positioned data) and queued in a DEPTH-entry FIFO. The head entry is
// presented to memory. Misaligned stores are dropped and reported with a
// one-cycle pulse plus the offending address.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        misalign,
  output logic [63:0] misalign_addr,
  output logic        busy
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [63:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];
  logic [7:0]  mask_mem [DEPTH];

  logic        push;
  logic        pop;
  logic        misaligned;
  logic        enq;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic [63:0] byte_mask;

  assign req_ready = (count < DEPTH_C);
  assign mem_valid = (count != '0);
  assign busy      = mem_valid;
  assign push      = req_valid && req_ready;
  assign pop       = mem_valid && mem_ready;
  assign enq       = push && !misaligned;

  // Head entry drives the write port; fields read as zero while empty.
  assign mem_addr  = mem_valid ? addr_mem[head] : '0;
  assign mem_wdata = mem_valid ? data_mem[head] : '0;
  assign mem_wmask = mem_valid ? mask_mem[head] : '0;

  // Alignment check and lane formatting of the incoming store.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    misaligned = 1'b0;
    base_mask  = 8'h01;
    byte_mask  = '0;
    case (req_size)
      2'd0: begin
        base_mask  = 8'h01;
        misaligned = 1'b0;
      end
      2'd1: begin
        base_mask  = 8'h03;
        misaligned = req_addr[0];
      end
      2'd2: begin
        base_mask  = 8'h0F;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: begin
        base_mask  = 8'hFF;
        misaligned = (req_addr[2:0] != 3'b000);
      end
    endcase
    lane_mask = base_mask << req_addr[2:0];
    for (int i = 0; i < 8; i++) begin
      byte_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    // Shifting first then masking drops both the unused upper source bytes
    // and anything shifted past the lane, matching "mask to size, then shift".
    lane_data = (req_wdata << {req_addr[2:0], 3'b000}) & byte_mask;
  end

  // Entry storage: written on enqueue, never reset.
  // NOTE: the data arrays carry no reset; validity lives in count/head/tail,
  // so clearing storage would only cost reset fan-out for no behaviour.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      addr_mem[tail] <= {req_addr[63:3], 3'b000};
      data_mem[tail] <= lane_data;
      mask_mem[tail] <= lane_mask;
    end
  end

  // Occupancy tracking and pointer updates.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({enq, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Misalignment reporting: one-cycle pulse and sticky address.
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= push && misaligned;
      if (push && misaligned) begin
        misalign_addr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus a randomized
// run against a queue-based reference model of the store buffer.
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        misalign;
  logic [63:0] misalign_addr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } wr_t;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .misalign(misalign), .misalign_addr(misalign_addr), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference formatting: walk byte lanes, copying source bytes into place.
  function automatic wr_t model_entry(logic [63:0] a, logic [63:0] d, logic [1:0] s);
    wr_t e;
    int nb  = 1 << s;
    int off = int'(a[2:0]);
    e.a = a - 64'(off);
    e.d = '0;
    e.m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + nb) begin
        e.m[i] = 1'b1;
        e.d[8*i +: 8] = d[8*(i-off) +: 8];
      end
    end
    return e;
  endfunction

  function automatic bit model_misaligned(logic [63:0] a, logic [1:0] s);
    return (a % (64'd1 << s)) != 0;
  endfunction

  task automatic drive(bit v, logic [63:0] a, logic [63:0] d, logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, '0, '0, 2'd0);
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (mem_wmask !== 8'h00) begin bad++; $display("FAIL reset_wmask got=%h exp=00", mem_wmask); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%0b exp=0", misalign); end
    total++; if (misalign_addr !== 64'h0) begin bad++; $display("FAIL reset_misalign_addr got=%h exp=0", misalign_addr); end
  endtask

  task automatic test_byte_store();
    mem_ready = 1'b0;
    drive(1, 64'h8000_0005, 64'hAB, 2'd0);
    tick();
    drive(0, '0, '0, 2'd0);
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL byte_valid got=%0b exp=1", mem_valid); end
    total++; if (mem_addr !== 64'h8000_0000) begin bad++; $display("FAIL byte_addr got=%h exp=80000000", mem_addr); end
    total++; if (mem_wmask !== 8'h20) begin bad++; $display("FAIL byte_wmask got=%h exp=20", mem_wmask); end
    total++; if (mem_wdata !== 64'h0000_AB00_0000_0000) begin bad++; $display("FAIL byte_wdata got=%h exp=0000ab0000000000", mem_wdata); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL byte_drain got=%0b exp=0", mem_valid); end
  endtask

  task automatic test_word_store();
    mem_ready = 1'b0;
    drive(1, 64'h8000_0004, 64'h1234_5678_9ABC_DEF0, 2'd2);
    tick();
    drive(0, '0, '0, 2'd0);
    total++; if (mem_addr !== 64'h8000_0000) begin bad++; $display("FAIL word_addr got=%h exp=80000000", mem_addr); end
    total++; if (mem_wmask !== 8'hF0) begin bad++; $display("FAIL word_wmask got=%h exp=f0", mem_wmask); end
    total++; if (mem_wdata !== 64'h9ABC_DEF0_0000_0000) begin bad++; $display("FAIL word_wdata got=%h exp=9abcdef000000000", mem_wdata); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL word_drain_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_misalign();
    mem_ready = 1'b1;
    drive(1, 64'h8000_0003, 64'hBEEF, 2'd1);
    tick();
    drive(0, '0, '0, 2'd0);
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%0b exp=1", misalign); end
    total++; if (misalign_addr !== 64'h8000_0003) begin bad++; $display("FAIL mis_addr got=%h exp=80000003", misalign_addr); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL mis_no_write got=%0b exp=0", mem_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%0b exp=1", req_ready); end
    tick();
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%0b exp=0", misalign); end
    total++; if (misalign_addr !== 64'h8000_0003) begin bad++; $display("FAIL mis_addr_hold got=%h exp=80000003", misalign_addr); end
    mem_ready = 1'b0;
  endtask

  task automatic test_stall();
    wr_t ea = model_entry(64'h1000, 64'h11, 2'd0);
    wr_t eb = model_entry(64'h2002, 64'h2233, 2'd1);
    wr_t ec = model_entry(64'h3000, 64'h0102_0304_0506_0708, 2'd3);
    mem_ready = 1'b0;
    drive(1, 64'h1000, 64'h11, 2'd0);
    tick();
    drive(1, 64'h2002, 64'h2233, 2'd1);
    tick();
    drive(1, 64'h3000, 64'h0102_0304_0506_0708, 2'd3);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_full got=%0b exp=0", req_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b exp=0", k, req_ready); end
      total++; if (mem_addr !== ea.a || mem_wdata !== ea.d || mem_wmask !== ea.m)
        begin bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%h exp=%h/%h/%h", k, mem_addr, mem_wdata, mem_wmask, ea.a, ea.d, ea.m); end
    end
    mem_ready = 1'b1;
    tick();
    total++; if (mem_addr !== eb.a || mem_wdata !== eb.d || mem_wmask !== eb.m)
      begin bad++; $display("FAIL stall_second got=%h/%h/%h exp=%h/%h/%h", mem_addr, mem_wdata, mem_wmask, eb.a, eb.d, eb.m); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_rise got=%0b exp=1", req_ready); end
    tick();
    drive(0, '0, '0, 2'd0);
    total++; if (mem_addr !== ec.a || mem_wdata !== ec.d || mem_wmask !== ec.m)
      begin bad++; $display("FAIL stall_third got=%h/%h/%h exp=%h/%h/%h", mem_addr, mem_wdata, mem_wmask, ec.a, ec.d, ec.m); end
    tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%0b exp=0", mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [63:0] a = {32'h0, $urandom} & ~64'h7;
      logic [63:0] d = {$urandom, $urandom};
      wr_t e = model_entry(a, d, 2'd3);
      drive(1, a, d, 2'd3);
      tick();
      total++; if (mem_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b1)
        begin bad++; $display("FAIL b2b_flags[%0d] got=%0b%0b%0b exp=111", k, mem_valid, busy, req_ready); end
      total++; if (mem_addr !== e.a || mem_wdata !== e.d)
        begin bad++; $display("FAIL b2b_head[%0d] got=%h/%h exp=%h/%h", k, mem_addr, mem_wdata, e.a, e.d); end
    end
    drive(0, '0, '0, 2'd0);
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", busy); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    drive(1, 64'h40, 64'h5, 2'd0);
    tick();
    drive(1, 64'h48, 64'h6, 2'd0);
    tick();
    total++; if (mem_valid !== 1'b1 || req_ready !== 1'b0)
      begin bad++; $display("FAIL rmid_prefull got=%0b%0b exp=10", mem_valid, req_ready); end
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, '0, '0, 2'd0);
    mem_ready = 1'b0;
    total++; if (mem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
      begin bad++; $display("FAIL rmid_flags got=%0b%0b%0b exp=001", mem_valid, busy, req_ready); end
    tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_write got=%0b exp=0", mem_valid); end
  endtask

  task automatic test_random();
    wr_t q[$];
    bit  exp_mis = 1'b0;
    logic [63:0] exp_maddr = misalign_addr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit exp_ready = (q.size() < DEPTH);
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", cyc, req_ready, exp_ready); end
      total++; if (mem_valid !== (q.size() != 0) || busy !== (q.size() != 0))
        begin bad++; $display("FAIL rnd_valid[%0d] got=%0b%0b exp=%0b", cyc, mem_valid, busy, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (mem_addr !== q[0].a || mem_wdata !== q[0].d || mem_wmask !== q[0].m)
          begin bad++; $display("FAIL rnd_head[%0d] got=%h/%h/%h exp=%h/%h/%h", cyc, mem_addr, mem_wdata, mem_wmask, q[0].a, q[0].d, q[0].m); end
      end
      total++; if (misalign !== exp_mis || misalign_addr !== exp_maddr)
        begin bad++; $display("FAIL rnd_mis[%0d] got=%0b/%h exp=%0b/%h", cyc, misalign, misalign_addr, exp_mis, exp_maddr); end
      begin
        bit v = ($urandom_range(0, 3) != 0);
        logic [63:0] a = {$urandom, $urandom};
        logic [63:0] d = {$urandom, $urandom};
        logic [1:0]  s = 2'($urandom_range(0, 3));
        bit do_push, do_pop, mis;
        if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << s) - 64'd1);
        mem_ready = ($urandom_range(0, 2) != 0);
        drive(v, a, d, s);
        do_push = v && exp_ready;
        do_pop  = (q.size() != 0) && mem_ready;
        mis     = model_misaligned(a, s);
        if (do_pop) void'(q.pop_front());
        if (do_push && !mis) q.push_back(model_entry(a, d, s));
        exp_mis = do_push && mis;
        if (exp_mis) exp_maddr = a;
      end
      tick();
    end
    drive(0, '0, '0, 2'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    drive(0, '0, '0, 2'd0);
    test_reset();
    test_byte_store();
    test_word_store();
    test_misalign();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
